// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory loader: receives a framed byte stream, checks
// length, word width and XOR checksum, writes 26-bit words and gates the core reset.
module inst_mem_loader #(
    parameter int          INST_W    = 26,
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_data,
    output logic              core_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  checksum;
    logic [1:0]  byte_idx;
    logic [15:0] len;
    logic [23:0] word_buf;

    logic        accept;
    logic        commit;
    logic [31:0] word32;
    logic        word_too_wide;
    logic [16:0] len_rx;
    logic        last_word;

    // Flags and handshake depend on state alone, so they are glitch-free and
    // in_ready never loops back through in_valid.
    assign in_ready = (state != S_DONE) && (state != S_ERROR);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);
    assign core_rst = (state != S_DONE);

    assign accept        = in_valid && in_ready;
    assign word32        = {in_data, word_buf};
    assign word_too_wide = |(word32 >> INST_W);
    assign len_rx        = {1'b0, in_data, len[7:0]};
    assign last_word     = (17'(words_loaded) + 17'd1) == {1'b0, len};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state <= S_SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        state_next = state;
        commit     = 1'b0;
        case (state)
            S_SYNC: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    if (len_rx == 17'd0 || len_rx > MAX_WORDS) begin
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && byte_idx == 2'd3) begin
                    if (word_too_wide) begin
                        state_next = S_ERROR;
                    end else begin
                        commit = 1'b1;
                        if (last_word) begin
                            state_next = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_next = (in_data == checksum) ? S_DONE : S_ERROR;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum     <= 8'd0;
            byte_idx     <= 2'd0;
            len          <= 16'd0;
            word_buf     <= 24'd0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            words_loaded <= '0;
        end else begin
            mem_we <= commit;

            if (accept) begin
                case (state)
                    S_SYNC: begin
                        checksum <= 8'd0;
                    end
                    S_LEN_LO: begin
                        len[7:0] <= in_data;
                        checksum <= checksum ^ in_data;
                    end
                    S_LEN_HI: begin
                        len[15:8] <= in_data;
                        checksum  <= checksum ^ in_data;
                    end
                    S_DATA: begin
                        checksum <= checksum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    word_buf[7:0]   <= in_data;
                            2'd1:    word_buf[15:8]  <= in_data;
                            2'd2:    word_buf[23:16] <= in_data;
                            default: word_buf        <= word_buf;
                        endcase
                    end
                    default: begin
                        checksum <= checksum;
                    end
                endcase
            end

            // The running word count doubles as the next write address.
            if (commit) begin
                mem_addr     <= words_loaded[ADDR_W-1:0];
                mem_data     <= word32[INST_W-1:0];
                words_loaded <= words_loaded + 1'b1;
            end
        end
    end

endmodule
